// File: rtl/md_unit_if.sv
// Multiply/divide unit bus: E-stage request (start/op/A/B) and the unit's busy/HI/LO view.
// No latency of its own; plain wires grouped for port convenience.
// No backpressure here; the pipeline stalls on (start | busy).
//
// Signals:
//   start  - E-stage instruction is a mult/div-class op
//   op     - 4-bit operation code
//   A, B   - forwarded rs / rt operands
//   busy   - unit has an operation in flight
//   HI, LO - architectural HI / LO registers
interface md_unit_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;

  // master drives requests (pipeline side), slave is the md_unit itself
  modport master (output start, op, A, B, input busy, HI, LO);
  modport slave  (input start, op, A, B, output busy, HI, LO);
endinterface

// File: rtl/md_unit.sv
// Iterative-latency MIPS multiply/divide unit owning the HI/LO registers.
// Latency: mult-class MULT_CYCLES, div-class DIV_CYCLES (busy high that long); mthi/mtlo one edge.
// Backpressure: start is ignored while busy; the hazard unit must stall on (start | busy).
//
// Ports: clk, reset (async active-high), bus (md_unit_if.slave: start, op, A, B -> busy, HI, LO).
// Optional feature: define MD_UNIT_MADD_EN to enable madd/maddu/msub/msubu (ops 6..9);
// without it those codes behave as undefined no-ops.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset,
  md_unit_if.slave  bus
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  op_q, op_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        busy_q, busy_d;

  // Datapath, all from the operands latched at start.
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, uq, ur, sq, sr, dq, dr;

  assign prod_s = $signed({{32{a_q[31]}}, a_q}) * $signed({{32{b_q[31]}}, b_q});
  assign prod_u = {32'd0, a_q} * {32'd0, b_q};

  // Signed divide through magnitudes: avoids the -2^31 / -1 overflow corner,
  // which falls out naturally as quotient 0x80000000, remainder 0.
  assign abs_a = a_q[31] ? (32'd0 - a_q) : a_q;
  assign abs_b = b_q[31] ? (32'd0 - b_q) : b_q;
  assign uq    = abs_a / abs_b;
  assign ur    = abs_a % abs_b;
  assign sq    = (a_q[31] ^ b_q[31]) ? (32'd0 - uq) : uq;
  assign sr    = a_q[31] ? (32'd0 - ur) : ur;   // remainder follows dividend sign
  assign dq    = a_q / b_q;
  assign dr    = a_q % b_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      op_q    <= 4'd0;
      a_q     <= 32'd0;
      b_q     <= 32'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      busy_q  <= busy_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    busy_d  = busy_q;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          case (bus.op)
            4'd0, 4'd1,
`ifdef MD_UNIT_MADD_EN
            4'd6, 4'd7, 4'd8, 4'd9,
`endif
            4'd2, 4'd3: begin
              op_d    = bus.op;
              a_d     = bus.A;
              b_d     = bus.B;
              cnt_d   = (bus.op == 4'd2 || bus.op == 4'd3) ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
              busy_d  = 1'b1;
              state_d = RUN;
            end
            4'd4:    hi_d = bus.A;
            4'd5:    lo_d = bus.A;
            default: ;  // undefined codes leave all state alone
          endcase
        end
      end

      RUN: begin
        cnt_d = cnt_q - 4'd1;
        // Completion edge: the counter reaches zero here.
        if (cnt_q == 4'd1) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          case (op_q)
            4'd0: {hi_d, lo_d} = prod_s;
            4'd1: {hi_d, lo_d} = prod_u;
            4'd2: if (b_q != 32'd0) {hi_d, lo_d} = {sr, sq};
            4'd3: if (b_q != 32'd0) {hi_d, lo_d} = {dr, dq};
`ifdef MD_UNIT_MADD_EN
            // Accumulate against HI/LO as they stand at completion.
            4'd6: {hi_d, lo_d} = {hi_q, lo_q} + prod_s;
            4'd7: {hi_d, lo_d} = {hi_q, lo_q} + prod_u;
            4'd8: {hi_d, lo_d} = {hi_q, lo_q} - prod_s;
            4'd9: {hi_d, lo_d} = {hi_q, lo_q} - prod_u;
`endif
            default: ;
          endcase
        end
      end

      default: state_d = IDLE;
    endcase
  end

  assign bus.busy = busy_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_md_unit.sv
// Testbench for md_unit: randomized and directed ops against an arithmetic reference model.
// Expected HI/LO/busy-length are queued at issue; a negedge monitor pops on completion.
// Driver waits (bounded) for each result before issuing the next op.
module tb_md_unit;
  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  md_unit_if mif();

  md_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (mif)
  );

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    int unsigned len;
  } exp_t;

  exp_t        exp_q[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] m_hi = 32'd0;
  logic [31:0] m_lo = 32'd0;
  bit          in_flight = 1'b0;
  int unsigned busy_cnt = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Reference model: architectural effect of one accepted op; returns busy length.
  function automatic int unsigned model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, q, r;
    longint unsigned ua, ub, uqq, urr;
    logic [63:0]     acc;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    acc = {m_hi, m_lo};
    case (op)
      4'd0: begin acc = 64'(sa * sb); {m_hi, m_lo} = acc; return MC; end
      4'd1: begin acc = ua * ub;      {m_hi, m_lo} = acc; return MC; end
      4'd2: begin
        if (b != 32'd0) begin
          q = sa / sb; r = sa % sb;
          m_lo = q[31:0]; m_hi = r[31:0];
        end
        return DC;
      end
      4'd3: begin
        if (b != 32'd0) begin
          uqq = ua / ub; urr = ua % ub;
          m_lo = uqq[31:0]; m_hi = urr[31:0];
        end
        return DC;
      end
      4'd4: begin m_hi = a; return 0; end
      4'd5: begin m_lo = a; return 0; end
`ifdef MD_UNIT_MADD_EN
      4'd6: begin acc = acc + 64'(sa * sb); {m_hi, m_lo} = acc; return MC; end
      4'd7: begin acc = acc + ua * ub;      {m_hi, m_lo} = acc; return MC; end
      4'd8: begin acc = acc - 64'(sa * sb); {m_hi, m_lo} = acc; return MC; end
      4'd9: begin acc = acc - ua * ub;      {m_hi, m_lo} = acc; return MC; end
`endif
      default: return 0;
    endcase
  endfunction

  // Monitor: counts busy cycles of an accepted op and compares when it finishes.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (reset) begin
        in_flight = 1'b0;
      end else begin
        if (in_flight) begin
          if (mif.busy) begin
            busy_cnt++;
          end else begin
            in_flight = 1'b0;
            if (exp_q.size() == 0) begin
              checks++; errors++;
              $display("FAIL spurious_completion: got HI=%h LO=%h expected no result", mif.HI, mif.LO);
            end else begin
              e = exp_q.pop_front();
              check("HI", mif.HI, e.hi);
              check("LO", mif.LO, e.lo);
              check("busy_len", busy_cnt, e.len);
            end
          end
        end
        if (!in_flight && mif.start && !mif.busy) begin
          in_flight = 1'b1;
          busy_cnt  = 0;
        end
      end
    end
  end

  // Issue one op; optionally inject an extra div start while the first op runs.
  task automatic run(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input bit inject);
    exp_t e;
    @(posedge clk); #2;
    mif.start = 1'b1; mif.op = op; mif.A = a; mif.B = b;
    e.len = model(op, a, b);
    e.hi = m_hi; e.lo = m_lo;
    exp_q.push_back(e);
    @(posedge clk); #2;
    mif.start = 1'b0; mif.op = 4'($urandom_range(0, 15)); mif.A = $urandom; mif.B = $urandom;
    if (inject) begin
      @(posedge clk); #2;
      mif.start = 1'b1; mif.op = 4'd2; mif.A = 32'd1000; mif.B = 32'd3;
      @(posedge clk); #2;
      mif.start = 1'b0;
    end
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
      @(negedge clk); #1;
      mif.A = $urandom; mif.B = $urandom;  // operand changes in flight must not matter
    end
    check("completion_pending", exp_q.size(), 32'd0);
    exp_q.delete();
  endtask

  initial begin
    mif.start = 1'b0; mif.op = 4'd0; mif.A = 32'd0; mif.B = 32'd0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", mif.busy, 32'd0);
    check("reset_HI", mif.HI, 32'd0);
    check("reset_LO", mif.LO, 32'd0);
    @(posedge clk); #2 reset = 1'b0;

    run(4'd0, 32'hFFFFFFFE, 32'd3, 1'b0);
    check("mult_HI", mif.HI, 32'hFFFFFFFF);
    check("mult_LO", mif.LO, 32'hFFFFFFFA);
    run(4'd3, 32'd7, 32'd2, 1'b0);
    check("divu_LO", mif.LO, 32'd3);
    check("divu_HI", mif.HI, 32'd1);
    run(4'd2, 32'hFFFFFFF9, 32'd2, 1'b0);
    check("div_LO", mif.LO, 32'hFFFFFFFD);
    check("div_HI", mif.HI, 32'hFFFFFFFF);
    run(4'd2, 32'h80000000, 32'hFFFFFFFF, 1'b0);
    check("div_ovf_LO", mif.LO, 32'h80000000);
    check("div_ovf_HI", mif.HI, 32'd0);
    run(4'd4, 32'h12345678, 32'd0, 1'b0);
    check("mthi_HI", mif.HI, 32'h12345678);
    run(4'd0, 32'd100, 32'd200, 1'b1);
    repeat (12) @(negedge clk);
    check("ignored_div_LO", mif.LO, 32'd20000);
    check("ignored_div_HI", mif.HI, 32'd0);
    run(4'd4, 32'hA, 32'd0, 1'b0);
    run(4'd5, 32'hB, 32'd0, 1'b0);
    run(4'd2, 32'd5, 32'd0, 1'b0);
    check("div0_HI", mif.HI, 32'hA);
    check("div0_LO", mif.LO, 32'hB);
    run(4'd4, 32'd0, 32'd0, 1'b0);
    run(4'd5, 32'hFFFFFFFF, 32'd0, 1'b0);
    run(4'd7, 32'd1, 32'd1, 1'b0);
`ifdef MD_UNIT_MADD_EN
    check("maddu_HI", mif.HI, 32'd1);
    check("maddu_LO", mif.LO, 32'd0);
`else
    check("maddu_HI", mif.HI, 32'd0);
    check("maddu_LO", mif.LO, 32'hFFFFFFFF);
`endif
    run(4'd12, 32'hDEADBEEF, 32'h1, 1'b0);

    for (int n = 0; n < 40; n++) begin
      logic [3:0]  op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h80000000; b = 32'hFFFFFFFF; end
        2: begin
          a = 32'($urandom_range(0, 50));
          b = 32'($urandom_range(1, 9));
          if ($urandom_range(0, 1) == 1) a = -a;
        end
        default: ;
      endcase
      run(op, a, b, 1'b0);
    end

    // Reset in cycle 3 of a div, mid-cycle.
    run(4'd4, 32'hCAFE0001, 32'd0, 1'b0);
    run(4'd5, 32'hCAFE0002, 32'd0, 1'b0);
    @(posedge clk); #2;
    mif.start = 1'b1; mif.op = 4'd2; mif.A = 32'd1000; mif.B = 32'd7;
    @(posedge clk); #2;
    mif.start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    reset = 1'b1;
    #1;
    check("async_rst_busy", mif.busy, 32'd0);
    check("async_rst_HI", mif.HI, 32'd0);
    check("async_rst_LO", mif.LO, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;
    // start presented while reset is high must be ignored
    @(posedge clk); #2;
    mif.start = 1'b1; mif.op = 4'd4; mif.A = 32'd55;
    @(posedge clk); #2;
    mif.start = 1'b0;
    reset = 1'b0;
    repeat (15) @(negedge clk);
    #1;
    check("post_rst_busy", mif.busy, 32'd0);
    check("post_rst_HI", mif.HI, 32'd0);
    check("post_rst_LO", mif.LO, 32'd0);
    run(4'd1, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0);
    check("multu_HI", mif.HI, 32'hFFFFFFFE);
    check("multu_LO", mif.LO, 32'h00000001);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule

// File: doc/md_unit.md
MD_UNIT -- requirements
Module: md_unit

Interface
REQ-001 Parameter MULT_CYCLES, default 5, busy duration of mult/multu (and madd/maddu/msub/msubu when compiled in).
REQ-002 Parameter DIV_CYCLES, default 10, busy duration of div/divu.
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 start  input  1  E-stage instruction is a mult/div-class op; sampled on posedge.
REQ-006 op  input  4  0=mult 1=multu 2=div 3=divu 4=mthi 5=mtlo 6=madd 7=maddu 8=msub 9=msubu; other codes are no-ops.
REQ-007 A  input  32  operand rs, forwarded E-stage value.
REQ-008 B  input  32  operand rt, forwarded E-stage value.
REQ-009 busy  output  1  registered; high while an operation is in flight.
REQ-010 HI  output  32  architectural HI register.
REQ-011 LO  output  32  architectural LO register.

Function
REQ-012 States: IDLE, RUN; the down-counter is 4 bits, sized to hold max(MULT_CYCLES, DIV_CYCLES).
REQ-013 In IDLE, with start=1 and op in {0,1,2,3,6..9}, the block latches A, B and op, loads the counter with the op's cycle count, sets busy=1 at that edge, and enters RUN.
REQ-014 In IDLE, with start=1 and op=4 or op=5, the block writes A to HI or LO at that edge; busy stays 0.
REQ-015 In RUN, the counter decrements each cycle; at the edge where it reaches 0 the block writes HI/LO, sets busy=0 and enters IDLE.
REQ-016 Latency: an op with N cycles raises busy for exactly N cycles; the new HI/LO is visible in cycle N+1 after the start cycle.
REQ-017 start is ignored in RUN; the hazard unit stalls while (start | busy).
REQ-018 mult: {HI,LO} = signed A × signed B, full 64-bit; multu uses the unsigned product.
REQ-019 div: LO = quotient truncated toward zero, HI = remainder with the dividend's sign; divu is the unsigned equivalent.
REQ-020 div 0x80000000 / 0xFFFFFFFF gives LO=0x80000000, HI=0.
REQ-021 Divide by zero (B=0): busy runs the full DIV_CYCLES; HI/LO are left unchanged.
REQ-022 Results are computed from the operands latched at start, so input changes during RUN have no effect.
REQ-023 Undefined op codes with start=1 change no state.

Reset
REQ-024 Asserting reset at any time, including mid-RUN, immediately forces HI=0, LO=0, busy=0, counter=0 and state=IDLE.
REQ-025 Any in-flight result is discarded on reset.
REQ-026 start is ignored while reset is high.

Configuration
REQ-027 Macro MD_UNIT_MADD_EN controls the multiply-accumulate ops.
REQ-028 With MD_UNIT_MADD_EN defined, ops 6..9 take MULT_CYCLES:
  - madd: {HI,LO} += signed product; maddu: += unsigned product.
  - msub: {HI,LO} -= signed product; msubu: -= unsigned product.
  - All are 64-bit modulo 2^64.
  - The HI/LO values read at the completion edge are used.
REQ-029 Without MD_UNIT_MADD_EN, ops 6..9 are undefined codes per REQ-023.

Verification
REQ-030 mult, A=0xFFFFFFFE, B=3 -> busy high for 5 cycles; then HI=0xFFFFFFFF, LO=0xFFFFFFFA.
REQ-031 divu, A=7, B=2 -> busy high for 10 cycles; then LO=3, HI=1. div, A=-7, B=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
REQ-032 mthi, A=0x12345678 -> HI=0x12345678 at the next edge, busy never high. A second start of div during RUN of a prior mult -> ignored; only the mult result is written.
REQ-033 div, B=0, with HI=0xA, LO=0xB -> busy for 10 cycles; HI=0xA and LO=0xB unchanged.
REQ-034 Reset asserted in cycle 3 of a div, asynchronous to clk -> busy, HI and LO read 0 before the next edge; no later write occurs.
REQ-035 With MD_UNIT_MADD_EN: HI=0, LO=0xFFFFFFFF, then maddu A=1, B=1 -> HI=1, LO=0. Without the macro, the same op leaves HI=0, LO=0xFFFFFFFF.
